// File: rtl/memoryaccess.sv
// Memory stage of the rv32i pipeline: registers execute results, runs load/store
// transactions on a pipelined Wishbone bus and hands formatted results to writeback.
module memoryaccess #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prev_clk_en,
    input  logic        prev_opcode_load,
    input  logic        prev_opcode_store,
    input  logic        prev_opcode_system,
    input  logic [2:0]  prev_funct3,
    input  logic [31:0] prev_addr,
    input  logic [31:0] prev_store_data,
    input  logic        prev_rd_w_en,
    input  logic [4:0]  prev_rd,
    input  logic [31:0] prev_rd_wdata,
    input  logic [31:0] prev_pc,
    input  logic        flush,
    input  logic        next_stall,
    output logic        clk_en,
    output logic        stall,
    output logic        opcode_load,
    output logic        opcode_system,
    output logic [2:0]  funct3,
    output logic        rd_w_en,
    output logic [4:0]  rd,
    output logic [31:0] rd_wdata,
    output logic [31:0] pc,
    output logic [31:0] data_load,
    output logic        load_misaligned,
    output logic        store_misaligned,
    output logic        bus_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wdata,
    output logic [3:0]  wb_sel,
    input  logic        wb_ack,
    input  logic        wb_stall,
    input  logic [31:0] wb_rdata
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_ACK = 2'd2} state_t;

    state_t        state_r, next_state_s;
    logic [TW-1:0] timer_r;
    logic [1:0]    addr_lo_r;
    logic          discard_r;
    logic          mem_s, misalign_s, issue_s, ack_s, tmo_s, abort_s, busy_s;

    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_sel = 4'b0001 << a;
            2'b01:   lane_sel = 4'b0011 << a;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // funct3[2] set means zero-extend (BU/HU)
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {a, 3'b000};
        case (f3[1:0])
            2'b00:   load_fmt = {{24{~f3[2] & sh[7]}}, sh[7:0]};
            2'b01:   load_fmt = {{16{~f3[2] & sh[15]}}, sh[15:0]};
            default: load_fmt = d;
        endcase
    endfunction

    // Request decode and next-state selection
    always_comb begin
        next_state_s = state_r;
        mem_s      = prev_opcode_load | prev_opcode_store;
        misalign_s = mem_s & (((prev_funct3[1:0] == 2'b01) & prev_addr[0]) |
                              ((prev_funct3[1:0] == 2'b10) & (prev_addr[1:0] != 2'b00)));
        issue_s    = (state_r == IDLE) & prev_clk_en & ~flush & ~next_stall & mem_s & ~misalign_s;
        busy_s     = (state_r == REQ) | (state_r == WAIT_ACK);
        ack_s      = wb_ack & (((state_r == REQ) & ~wb_stall) | (state_r == WAIT_ACK));
        tmo_s      = busy_s & ~ack_s & (timer_r == TW'(ACK_TIMEOUT - 1));
        // an unaccepted strobe may be withdrawn on flush; an accepted one must finish
        abort_s    = (state_r == REQ) & flush & wb_stall & ~tmo_s;
        case (state_r)
            IDLE: begin
                if (issue_s) next_state_s = REQ;
                else         next_state_s = IDLE;
            end
            REQ: begin
                if (ack_s | tmo_s | abort_s) next_state_s = IDLE;
                else if (!wb_stall)          next_state_s = WAIT_ACK;
                else                         next_state_s = REQ;
            end
            WAIT_ACK: begin
                if (ack_s | tmo_s) next_state_s = IDLE;
                else               next_state_s = WAIT_ACK;
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign stall = busy_s | next_stall;

    // State, bus and writeback-facing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;          timer_r <= '0;         addr_lo_r <= 2'b00;
            discard_r <= 1'b0;        clk_en <= 1'b0;        opcode_load <= 1'b0;
            opcode_system <= 1'b0;    funct3 <= 3'b000;      rd_w_en <= 1'b0;
            rd <= 5'd0;               rd_wdata <= 32'd0;     pc <= 32'd0;
            data_load <= 32'd0;       load_misaligned <= 1'b0;
            store_misaligned <= 1'b0; bus_err <= 1'b0;       wb_cyc <= 1'b0;
            wb_stb <= 1'b0;           wb_we <= 1'b0;         wb_addr <= 32'd0;
            wb_wdata <= 32'd0;        wb_sel <= 4'b0000;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        clk_en <= 1'b0; load_misaligned <= 1'b0;
                        store_misaligned <= 1'b0; bus_err <= 1'b0;
                    end else if (next_stall) begin
                        clk_en <= clk_en;
                    end else if (prev_clk_en) begin
                        clk_en           <= ~issue_s;
                        opcode_load      <= prev_opcode_load;
                        opcode_system    <= prev_opcode_system;
                        funct3           <= prev_funct3;
                        rd               <= prev_rd;
                        rd_wdata         <= prev_rd_wdata;
                        pc               <= prev_pc;
                        rd_w_en          <= prev_rd_w_en & ~misalign_s;
                        load_misaligned  <= misalign_s & prev_opcode_load;
                        store_misaligned <= misalign_s & prev_opcode_store;
                        bus_err          <= 1'b0;
                        if (issue_s) begin
                            wb_cyc    <= 1'b1;
                            wb_stb    <= 1'b1;
                            wb_we     <= prev_opcode_store;
                            wb_addr   <= {prev_addr[31:2], 2'b00};
                            wb_sel    <= lane_sel(prev_funct3, prev_addr[1:0]);
                            wb_wdata  <= lane_data(prev_funct3, prev_store_data);
                            addr_lo_r <= prev_addr[1:0];
                            timer_r   <= '0;
                            discard_r <= 1'b0;
                        end else begin
                            wb_stb <= 1'b0;
                        end
                    end else begin
                        clk_en <= 1'b0; load_misaligned <= 1'b0;
                        store_misaligned <= 1'b0; bus_err <= 1'b0;
                    end
                end
                REQ, WAIT_ACK: begin
                    timer_r   <= timer_r + TW'(1);
                    discard_r <= discard_r | flush;
                    if (ack_s) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        data_load <= load_fmt(funct3, addr_lo_r, wb_rdata);
                        clk_en    <= ~(discard_r | flush);
                    end else if (tmo_s) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        rd_w_en <= 1'b0;
                        bus_err <= ~(discard_r | flush);
                        clk_en  <= ~(discard_r | flush);
                    end else if (abort_s) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        clk_en <= 1'b0;
                    end else if (!wb_stall) begin
                        wb_stb <= 1'b0;
                    end else begin
                        wb_stb <= wb_stb;
                    end
                end
                default: begin
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                end
            endcase
        end
    end
endmodule
